mg_seq_div: RTL and testbench

//  Iterative unsigned restoring divider, the inverse partner of the generated multiplier datapath.

---
 rtl/mg_div_pkg.sv | 15 +
 rtl/mg_cps.sv | 30 +++
 rtl/mg_seq_div.sv | 135 +++++++++++++
 tb/tb_mg_seq_div.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mg_div_pkg.sv
// Shared types and constants for the mg_seq_div iterative divider.
package mg_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N = 8;

    // A zero divisor returns an all-ones quotient, built from this fill bit.
    localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/mg_cps.sv
// Ripple carry-propagate subtractor: diff = a - b, bout set when a < b.
module mg_cps #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign p = a ^ ~b;
    assign g = a & ~b;

    // a + ~b + 1 as a ripple chain; a missing final carry means a borrow.
    always_comb begin
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign diff = p ^ c[W-1:0];
    assign bout = ~c[W];

endmodule

// File: rtl/mg_seq_div.sv
// Iterative unsigned restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per cycle.
// Optional macro MG_DIV_EARLY_OUT_EN skips the first N iterations when the dividend's upper half is zero.
module mg_seq_div
    import mg_div_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div0,
    output logic [1:0]     dbg_state
);

    localparam int CNT_W = $clog2(2*N+1);

    state_t           state;
    state_t           state_next;
    logic [2*N-1:0]   q_reg;
    logic [N-1:0]     r_reg;
    logic [N-1:0]     d_reg;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             handshake;
    logic             last_iter;
    logic             early;
    logic [N:0]       t;
    logic [N:0]       diff;
    logic             bout;
    logic             take;
    logic [N-1:0]     r_next;
    logic [2*N-1:0]   q_next;

    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;
    assign last_iter = (cnt == CNT_W'(2*N-1));
    assign dbg_state = state;

`ifdef MG_DIV_EARLY_OUT_EN
    assign early = (dividend[2*N-1:N] == '0);
`else
    assign early = 1'b0;
`endif

    // R is always below D, so it is kept in N bits; T carries the extra shifted-in bit.
    assign t = {r_reg, q_reg[2*N-1]};

    mg_cps #(.W(N+1)) u_cps (
        .a    (t),
        .b    ({1'b0, d_reg}),
        .diff (diff),
        .bout (bout)
    );

    // Without a borrow diff < D, so diff[N] is always clear; folding it in keeps the full result used.
    assign take   = ~bout & ~diff[N];
    assign r_next = take ? diff[N-1:0] : t[N-1:0];
    assign q_next = {q_reg[2*N-2:0], take};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)    state_next = (divisor == '0) ? DONE : CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: if (handshake) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d_reg <= divisor;
                        r_reg <= '0;
                        div0  <= (divisor == '0);
                        if (divisor == '0) begin
                            q_reg     <= dividend;
                            cnt       <= '0;
                            quotient  <= {(2*N){DIV0_Q_BIT}};
                            remainder <= dividend[N-1:0];
                        end else if (early) begin
                            q_reg <= {dividend[N-1:0], {N{1'b0}}};
                            cnt   <= CNT_W'(N);
                        end else begin
                            q_reg <= dividend;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 1'b1;
                    if (last_iter) begin
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mg_seq_div.sv
// Directed self-checking bench for mg_seq_div (N=8); honours MG_DIV_EARLY_OUT_EN for latency.
module tb_mg_seq_div;
    import mg_div_pkg::*;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div0;
    logic [1:0]     dbg_state;

    int tests = 0;
    int fails = 0;
    logic [2*N+N:0] exp_q[$];

    mg_seq_div #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] dvd, input logic [7:0] dvs);
        if (dvs == 8'd0) return 1;
`ifdef MG_DIV_EARLY_OUT_EN
        if (dvd[15:8] == 8'd0) return N;
`endif
        return 2 * N;
    endfunction

    // One request/response; during stall cycles a second request is offered and must be ignored.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          input logic [15:0] eq, input logic [7:0] er, input logic ed,
                          input int stall);
        logic [2*N+N:0] e;
        int lat;
        exp_q.push_back({eq, er, ed});
        @(negedge clk);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        chk("in_ready_busy", in_ready, 0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk("latency", lat, exp_lat(dvd, dvs));
        e = exp_q.pop_front();
        chk("quotient", quotient, e[24:9]);
        chk("remainder", remainder, e[8:1]);
        chk("div0", div0, e[0]);
        if (stall > 0) begin
            in_valid = 1'b1;
            dividend = 16'd77;
            divisor  = 8'd5;
            repeat (stall) begin
                @(posedge clk);
                #1;
                chk("stall_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_quotient", quotient, e[24:9]);
                chk("stall_remainder", remainder, e[8:1]);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_quotient_hold", quotient, e[24:9]);
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  rs;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div0", div0, 0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 0);
        run_op(16'd65535, 8'd255, 16'd257,   8'd0,    1'b0, 0);
        run_op(16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 0);
        run_op(16'd1234,  8'd0,   16'hFFFF,  8'hD2,   1'b1, 0);
        run_op(16'd200,   8'd9,   16'd22,    8'd2,    1'b0, 0);
        run_op(16'h0100,  8'd9,   16'd28,    8'd4,    1'b0, 0);
        run_op(16'd0,     8'd5,   16'd0,     8'd0,    1'b0, 0);
        run_op(16'd1000,  8'd255, 16'd3,     8'd235,  1'b0, 0);
        run_op(16'd5,     8'd200, 16'd0,     8'd5,    1'b0, 0);
        run_op(16'd100,   8'd3,   16'd33,    8'd1,    1'b0, 5);

        // A request offered only while busy must not start a second operation.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_extra_valid", out_valid, 0);
            chk("no_extra_state", dbg_state, IDLE);
        end

        // Reset in the middle of 1000/7 aborts it.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("calc_state", dbg_state, CALC);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("abort_no_result", out_valid, 0);
        end
        run_op(16'd200, 8'd9, 16'd22, 8'd2, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            rd = 16'($urandom);
            rs = 8'($urandom_range(0, 255));
            if (i % 4 == 0) rd[15:8] = 8'd0;
            if (rs == 8'd0)
                run_op(rd, rs, 16'hFFFF, rd[7:0], 1'b1, $urandom_range(0, 3));
            else
                run_op(rd, rs, rd / {8'd0, rs}, 8'(rd % {8'd0, rs}), 1'b0, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
